// File: rtl/pwm_pkg.sv
// Shared widths and types for the complementary PWM generator.
// Pure declarations: no logic, no latency, no flow control.
package pwm_pkg;
  localparam int PWM_NCH = 3;
  localparam int PWM_CW  = 16;
  localparam int PWM_DW  = 10;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
endpackage

// File: rtl/pwm_deadtime.sv
// One complementary output pair with dead-time insertion; 1 cycle preout->pins.
// No backpressure; en low forces both drives low and clears the dead-time state.
module pwm_deadtime #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          dten,
  input  logic [DW-1:0] dt,
  input  logic          preout,
  output logic          outA,
  output logic          outB
);
  logic          last_q, last_d;
  logic [DW-1:0] ctr_q, ctr_d;
  logic          a_q, a_d;
  logic          b_q, b_d;

  always_comb begin
    last_d = last_q;
    ctr_d  = ctr_q;
    a_d    = 1'b0;
    b_d    = 1'b0;
    if (!en) begin
      last_d = 1'b0;
      ctr_d  = '0;
    end else if (!dten) begin
      last_d = preout;
      ctr_d  = '0;
      a_d    = preout;
      b_d    = ~preout;
    end else begin
      // Any edge, including a retoggle inside the gap, restarts the gap.
      if (preout != last_q) begin
        last_d = preout;
        ctr_d  = dt;
      end else if (ctr_q != '0) begin
        ctr_d = ctr_q - DW'(1);
      end
      a_d = last_d & (ctr_d == '0);
      b_d = ~last_d & (ctr_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b0;
      ctr_q  <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
    end else begin
      last_q <= last_d;
      ctr_q  <= ctr_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  assign outA = a_q;
  assign outB = b_q;
endmodule

// File: rtl/pwm_gen.sv
// Multi-channel complementary PWM: counter, shadowed config, sticky fault; 1 cycle to pins.
// Config is valid/ready: ready drops while a staged update waits for the next period boundary.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int NCH    = PWM_NCH,
  parameter int CW     = PWM_CW,
  parameter int DW     = PWM_DW,
  parameter int CENTER = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  input  logic              fault_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CW-1:0]     cfg_lim_i,
  input  logic [NCH*CW-1:0] cfg_mat_i,
  input  logic [NCH*DW-1:0] cfg_dt_i,
  input  logic              cfg_dten_i,
  output logic [NCH-1:0]    outA_o,
  output logic [NCH-1:0]    outB_o,
  output logic              period_o,
  output logic              fault_o
);
  logic [CW-1:0]     tc_q, tc_d;
  dir_e              dir_q, dir_d;
  logic [CW-1:0]     lim_q, lim_d, stg_lim_q, stg_lim_d;
  logic [NCH*CW-1:0] mat_q, mat_d, stg_mat_q, stg_mat_d;
  logic [NCH*DW-1:0] dt_q, dt_d, stg_dt_q, stg_dt_d;
  logic              dten_q, dten_d, stg_dten_q, stg_dten_d;
  logic              pending_q, pending_d;
  logic              fault_q, fault_d;
  logic              period_q, period_d;

  logic              accept, boundary, load, out_en;
  logic [NCH-1:0]    preout;

  assign accept   = cfg_valid_i & ~pending_q;
  assign boundary = run_i & ~fault_q & (tc_q == '0);
  // A fault arriving on the boundary edge suppresses both the load and the strobe.
  assign load     = boundary & ~fault_i & pending_q;
  assign out_en   = run_i & ~fault_d;

  always_comb begin
    tc_d       = tc_q;
    dir_d      = dir_q;
    lim_d      = lim_q;
    mat_d      = mat_q;
    dt_d       = dt_q;
    dten_d     = dten_q;
    stg_lim_d  = stg_lim_q;
    stg_mat_d  = stg_mat_q;
    stg_dt_d   = stg_dt_q;
    stg_dten_d = stg_dten_q;
    fault_d    = run_i & (fault_q | fault_i);
    period_d   = boundary & ~fault_i;
    pending_d  = accept | (pending_q & ~load);

    if (!run_i) begin
      tc_d  = '0;
      dir_d = DIR_UP;
    end else if (!fault_d) begin
      if (CENTER != 0) begin
        if (tc_q == '0) begin
          dir_d = DIR_UP;
          tc_d  = (lim_q == '0) ? '0 : CW'(1);
        end else if (tc_q >= lim_q) begin
          dir_d = DIR_DOWN;
          tc_d  = tc_q - CW'(1);
        end else begin
          tc_d = (dir_q == DIR_UP) ? tc_q + CW'(1) : tc_q - CW'(1);
        end
      end else begin
        dir_d = DIR_UP;
        tc_d  = (tc_q >= lim_q) ? '0 : tc_q + CW'(1);
      end
    end

    if (load) begin
      lim_d  = stg_lim_q;
      mat_d  = stg_mat_q;
      dt_d   = stg_dt_q;
      dten_d = stg_dten_q;
    end
    if (accept) begin
      stg_lim_d  = cfg_lim_i;
      stg_mat_d  = cfg_mat_i;
      stg_dt_d   = cfg_dt_i;
      stg_dten_d = cfg_dten_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tc_q       <= '0;
      dir_q      <= DIR_UP;
      lim_q      <= '0;
      mat_q      <= '0;
      dt_q       <= '0;
      dten_q     <= 1'b0;
      stg_lim_q  <= '0;
      stg_mat_q  <= '0;
      stg_dt_q   <= '0;
      stg_dten_q <= 1'b0;
      pending_q  <= 1'b0;
      fault_q    <= 1'b0;
      period_q   <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      dir_q      <= dir_d;
      lim_q      <= lim_d;
      mat_q      <= mat_d;
      dt_q       <= dt_d;
      dten_q     <= dten_d;
      stg_lim_q  <= stg_lim_d;
      stg_mat_q  <= stg_mat_d;
      stg_dt_q   <= stg_dt_d;
      stg_dten_q <= stg_dten_d;
      pending_q  <= pending_d;
      fault_q    <= fault_d;
      period_q   <= period_d;
    end
  end

  always_comb begin
    preout = '0;
    for (int k = 0; k < NCH; k++) begin
      preout[k] = (tc_q >= mat_q[k*CW +: CW]);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pwm_deadtime #(.DW(DW)) u_dt (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (out_en),
      .dten   (dten_q),
      .dt     (dt_q[k*DW +: DW]),
      .preout (preout[k]),
      .outA   (outA_o[k]),
      .outB   (outB_o[k])
    );
  end

  assign cfg_ready_o = ~pending_q;
  assign period_o    = period_q;
  assign fault_o     = fault_q;
endmodule

// File: tb/tb_pwm_gen.sv
// Bench: centre-aligned and edge-aligned instances side by side, checked every cycle
// against a behavioural model, plus duty/period counts over whole periods.
module tb_pwm_gen;
  localparam int NCH = 3;
  localparam int CW  = 8;
  localparam int DW  = 4;

  logic              clk = 1'b0;
  logic              rst_n, run_i, fault_i, cfg_dten_i;
  logic [1:0]        cfg_valid, cfg_ready, period, flt;
  logic [CW-1:0]     cfg_lim_i;
  logic [NCH*CW-1:0] cfg_mat_i;
  logic [NCH*DW-1:0] cfg_dt_i;
  logic [NCH-1:0]    out_a [2];
  logic [NCH-1:0]    out_b [2];

  int n_checks = 0;
  int n_fail   = 0;

  // configuration currently offered on the bus
  int c_lim, c_dten;
  int c_mat [NCH];
  int c_dt  [NCH];

  // reference model state, index 0 = centre-aligned, 1 = edge-aligned
  int m_tc [2];
  bit m_up [2];
  int m_lim [2], s_lim [2];
  int m_mat [2][NCH], s_mat [2][NCH];
  int m_dt  [2][NCH], s_dt  [2][NCH];
  bit m_dten [2], s_dten [2];
  bit m_pend [2], m_flt [2], m_per [2];
  bit m_last [2][NCH];
  int m_ctr  [2][NCH];
  bit m_a [2][NCH], m_b [2][NCH];
  bit acc_seen [2];

  int cnt_a [2], cnt_b [2], cnt_b1 [2], cnt_p [2];

  always #5 clk = ~clk;

  pwm_gen #(.NCH(NCH), .CW(CW), .DW(DW), .CENTER(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .fault_i(fault_i),
    .cfg_valid_i(cfg_valid[0]), .cfg_ready_o(cfg_ready[0]),
    .cfg_lim_i(cfg_lim_i), .cfg_mat_i(cfg_mat_i), .cfg_dt_i(cfg_dt_i),
    .cfg_dten_i(cfg_dten_i), .outA_o(out_a[0]), .outB_o(out_b[0]),
    .period_o(period[0]), .fault_o(flt[0]));

  pwm_gen #(.NCH(NCH), .CW(CW), .DW(DW), .CENTER(0)) u_dut_e (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .fault_i(fault_i),
    .cfg_valid_i(cfg_valid[1]), .cfg_ready_o(cfg_ready[1]),
    .cfg_lim_i(cfg_lim_i), .cfg_mat_i(cfg_mat_i), .cfg_dt_i(cfg_dt_i),
    .cfg_dten_i(cfg_dten_i), .outA_o(out_a[1]), .outB_o(out_b[1]),
    .period_o(period[1]), .fault_o(flt[1]));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the model for instance m, from the inputs seen at that edge.
  task automatic model_step(input int m);
    bit cen, acc, bnd, nflt, en, load, pre;
    int ntc;
    bit nup;
    if (!rst_n) begin
      m_tc[m] = 0; m_up[m] = 1; m_lim[m] = 0; s_lim[m] = 0;
      m_dten[m] = 0; s_dten[m] = 0; m_pend[m] = 0; m_flt[m] = 0; m_per[m] = 0;
      for (int k = 0; k < NCH; k++) begin
        m_mat[m][k] = 0; s_mat[m][k] = 0; m_dt[m][k] = 0; s_dt[m][k] = 0;
        m_last[m][k] = 0; m_ctr[m][k] = 0; m_a[m][k] = 0; m_b[m][k] = 0;
      end
      acc_seen[m] = 0;
      return;
    end
    cen  = (m == 0);
    acc  = cfg_valid[m] && !m_pend[m];
    bnd  = run_i && !m_flt[m] && (m_tc[m] == 0);
    nflt = run_i && (m_flt[m] || fault_i);
    en   = run_i && !nflt;
    load = bnd && !fault_i && m_pend[m];

    ntc = m_tc[m];
    nup = m_up[m];
    if (!run_i) begin
      ntc = 0; nup = 1;
    end else if (!nflt) begin
      if (cen) begin
        if (m_tc[m] == 0)               begin nup = 1; ntc = (m_lim[m] == 0) ? 0 : 1; end
        else if (m_tc[m] == m_lim[m])   begin nup = 0; ntc = m_lim[m] - 1; end
        else                            ntc = m_up[m] ? m_tc[m] + 1 : m_tc[m] - 1;
      end else begin
        ntc = (m_tc[m] >= m_lim[m]) ? 0 : m_tc[m] + 1;
      end
    end

    for (int k = 0; k < NCH; k++) begin
      pre = (m_tc[m] >= m_mat[m][k]);
      if (!en) begin
        m_last[m][k] = 0; m_ctr[m][k] = 0; m_a[m][k] = 0; m_b[m][k] = 0;
      end else if (!m_dten[m]) begin
        m_last[m][k] = pre; m_ctr[m][k] = 0; m_a[m][k] = pre; m_b[m][k] = !pre;
      end else begin
        if (pre != m_last[m][k]) begin
          m_last[m][k] = pre; m_ctr[m][k] = m_dt[m][k];
        end else if (m_ctr[m][k] > 0) begin
          m_ctr[m][k]--;
        end
        m_a[m][k] = m_last[m][k] && (m_ctr[m][k] == 0);
        m_b[m][k] = !m_last[m][k] && (m_ctr[m][k] == 0);
      end
    end

    m_per[m] = bnd && !fault_i;
    m_flt[m] = nflt;
    m_tc[m]  = ntc;
    m_up[m]  = nup;
    if (load) begin
      m_lim[m] = s_lim[m]; m_dten[m] = s_dten[m];
      for (int k = 0; k < NCH; k++) begin m_mat[m][k] = s_mat[m][k]; m_dt[m][k] = s_dt[m][k]; end
    end
    if (acc) begin
      s_lim[m] = c_lim; s_dten[m] = (c_dten != 0);
      for (int k = 0; k < NCH; k++) begin s_mat[m][k] = c_mat[k]; s_dt[m][k] = c_dt[k]; end
    end
    m_pend[m] = acc || (m_pend[m] && !load);
    acc_seen[m] = acc;
  endtask

  task automatic tick();
    logic [NCH-1:0] ea, eb;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < NCH; k++) begin ea[k] = m_a[m][k]; eb[k] = m_b[m][k]; end
      check_eq($sformatf("outA[%0d]", m), 32'(out_a[m]), 32'(ea));
      check_eq($sformatf("outB[%0d]", m), 32'(out_b[m]), 32'(eb));
      check_eq($sformatf("overlap[%0d]", m), 32'(out_a[m] & out_b[m]), 0);
      check_eq($sformatf("period[%0d]", m), 32'(period[m]), 32'(m_per[m]));
      check_eq($sformatf("fault[%0d]", m), 32'(flt[m]), 32'(m_flt[m]));
      check_eq($sformatf("ready[%0d]", m), 32'(cfg_ready[m]), 32'(!m_pend[m]));
      cnt_a[m]  += int'(out_a[m][0]);
      cnt_b[m]  += int'(out_b[m][0]);
      cnt_b1[m] += int'(out_b[m][1]);
      cnt_p[m]  += int'(period[m]);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_counts();
    for (int m = 0; m < 2; m++) begin cnt_a[m] = 0; cnt_b[m] = 0; cnt_b1[m] = 0; cnt_p[m] = 0; end
  endtask

  task automatic send_cfg(input int lim, input int m0, input int m1, input int m2,
                          input int d0, input int d1, input int d2, input int dten);
    int budget;
    c_lim = lim; c_dten = dten;
    c_mat[0] = m0; c_mat[1] = m1; c_mat[2] = m2;
    c_dt[0] = d0;  c_dt[1] = d1;  c_dt[2] = d2;
    cfg_lim_i  = CW'(lim);
    cfg_dten_i = dten[0];
    for (int k = 0; k < NCH; k++) begin
      cfg_mat_i[k*CW +: CW] = CW'(c_mat[k]);
      cfg_dt_i[k*DW +: DW]  = DW'(c_dt[k]);
    end
    cfg_valid = 2'b11;
    budget = 300;
    while (cfg_valid != 2'b00 && budget > 0) begin
      tick();
      for (int m = 0; m < 2; m++) if (acc_seen[m]) cfg_valid[m] = 1'b0;
      budget--;
    end
    if (cfg_valid != 2'b00) begin
      check_eq("cfg_accept_timeout", 32'(cfg_valid), 0);
      cfg_valid = 2'b00;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run_i = 1'b0; fault_i = 1'b0; cfg_valid = 2'b00;
    cfg_lim_i = '0; cfg_mat_i = '0; cfg_dt_i = '0; cfg_dten_i = 1'b0;
    c_lim = 0; c_dten = 0;
    for (int k = 0; k < NCH; k++) begin c_mat[k] = 0; c_dt[k] = 0; end
    clear_counts();
    run_cycles(2);
    for (int m = 0; m < 2; m++) begin
      check_eq("rst_outA", 32'(out_a[m]), 0);
      check_eq("rst_outB", 32'(out_b[m]), 0);
      check_eq("rst_period", 32'(period[m]), 0);
      check_eq("rst_fault", 32'(flt[m]), 0);
      check_eq("rst_ready", 32'(cfg_ready[m]), 1);
    end
    rst_n = 1'b1;

    // plain complementary, lim=4 mat0=2
    send_cfg(4, 2, 0, 5, 1, 2, 3, 0);
    run_i = 1'b1;
    run_cycles(20);
    clear_counts();
    run_cycles(40);
    check_eq("c_dutyA", cnt_a[0], 25);
    check_eq("c_dutyB", cnt_b[0], 15);
    check_eq("c_period", cnt_p[0], 5);
    check_eq("e_dutyA", cnt_a[1], 24);
    check_eq("e_dutyB", cnt_b[1], 16);
    check_eq("e_period", cnt_p[1], 8);

    // same with dead time 1 on channel 0, loaded at the next boundary
    send_cfg(4, 2, 0, 5, 1, 2, 3, 1);
    run_cycles(20);
    clear_counts();
    run_cycles(40);
    check_eq("c_dt_dutyA", cnt_a[0], 20);
    check_eq("c_dt_dutyB", cnt_b[0], 10);
    check_eq("e_dt_dutyA", cnt_a[1], 16);
    check_eq("e_dt_dutyB", cnt_b[1], 8);

    // mid-period duty change: ready low until the load, model tracks timing
    run_cycles(3);
    send_cfg(4, 3, 0, 5, 1, 2, 3, 0);
    run_cycles(12);

    // one-cycle fault, sticky until run drops
    fault_i = 1'b1;
    tick();
    fault_i = 1'b0;
    for (int m = 0; m < 2; m++) begin
      check_eq("flt_set", 32'(flt[m]), 1);
      check_eq("flt_outA", 32'(out_a[m] | out_b[m]), 0);
    end
    run_cycles(6);
    check_eq("flt_sticky", 32'(flt), 32'(2'b11));
    run_i = 1'b0;
    tick();
    check_eq("flt_clear", 32'(flt), 0);
    run_i = 1'b1;
    run_cycles(10);

    // extreme matches: ch0 always high, ch1 always low, 3-cycle dead time
    send_cfg(4, 0, 5, 2, 3, 3, 3, 1);
    run_cycles(20);
    clear_counts();
    run_cycles(40);
    for (int m = 0; m < 2; m++) begin
      check_eq("mat0_constA", cnt_a[m], 40);
      check_eq("mat_over_constB", cnt_b1[m], 40);
    end

    // synchronous reset mid-period
    run_cycles(3);
    rst_n = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      check_eq("midrst_out", 32'(out_a[m] | out_b[m]), 0);
      check_eq("midrst_period", 32'(period[m]), 0);
    end
    rst_n = 1'b1;

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      run_i = 1'b0;
      tick();
      run_i = 1'b1;
      send_cfg($urandom_range(12, 1), $urandom_range(14, 0), $urandom_range(14, 0),
               $urandom_range(14, 0), $urandom_range(3, 0), $urandom_range(3, 0),
               $urandom_range(3, 0), $urandom_range(1, 0));
      for (int i = 0; i < 120; i++) begin
        fault_i = ($urandom_range(69, 0) == 0);
        run_i   = ($urandom_range(89, 0) != 0);
        tick();
      end
      fault_i = 1'b0;
      run_i   = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
